// File: rtl/game_pkg.sv
// Shared definitions for the factorization game: the controller's state codes
// and the verdict/HP codes exchanged between the judge and the controller.
package game_pkg;

  typedef enum logic [3:0] {
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_DRAW     = 4'b0110,
    ST_WRONG    = 4'b0111,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } game_state_e;

  localparam logic [1:0] JUDG_NONE   = 2'b00;
  localparam logic [1:0] JUDG_A      = 2'b01;
  localparam logic [1:0] JUDG_B      = 2'b10;
  localparam logic [1:0] JUDG_BOTH   = 2'b11;

  localparam logic [1:0] WRONG_NONE  = 2'b00;
  localparam logic [1:0] WRONG_A_OK  = 2'b01;
  localparam logic [1:0] WRONG_A_BAD = 2'b11;

  localparam logic [1:0] HP_NONE     = 2'b00;
  localparam logic [1:0] HP_B_OUT    = 2'b01;
  localparam logic [1:0] HP_A_OUT    = 2'b10;

endpackage

// File: rtl/hp_counter.sv
// One player's hit points: saturating decrement by DMG, reload to INIT,
// and a zero flag taken straight from the register.
module hp_counter #(
  parameter int CW   = 2,
  parameter int INIT = 3,
  parameter int DMG  = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          dec,
  input  logic          reload,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Damage larger than the remaining HP floors at zero instead of wrapping.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] v);
    if (int'(v) > DMG) sat_dec = v - CW'(DMG);
    else               sat_dec = '0;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    if (reload)   cnt_d = CW'(INIT);
    else if (dec) cnt_d = sat_dec(cnt_q);
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= CW'(INIT);
    else     cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/judge_hp.sv
// Answer judge and HP keeper: samples player answers during INPUT, returns
// verdict codes to the controller, and tracks HP plus player B's lockout.
module judge_hp
  import game_pkg::*;
#(
  parameter int W        = 8,
  parameter int HP_INIT  = 3,
  parameter int DMG      = 1,
  parameter int LOCK_CYC = 4,
  localparam int HPW     = $clog2(HP_INIT + 1)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [3:0]     STATE,
  input  logic [W-1:0]   FACT_P,
  input  logic [W-1:0]   FACT_Q,
  input  logic           ANS_A_VLD,
  input  logic [W-1:0]   ANS_A,
  input  logic           ANS_B_VLD,
  input  logic [W-1:0]   ANS_B,
  output logic [1:0]     JUDG,
  output logic [1:0]     WRONG,
  output logic [1:0]     HP,
  output logic [HPW-1:0] HP_A,
  output logic [HPW-1:0] HP_B,
  output logic           LOCK_B
);

  localparam int LCW = (LOCK_CYC < 1) ? 1 : $clog2(LOCK_CYC + 1);

  logic [1:0]     judg_q, judg_d;
  logic [1:0]     wrong_q, wrong_d;
  logic [1:0]     hp_q, hp_d;
  logic           lock_b_q, lock_b_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [3:0]     prev_state_q, prev_state_d;

  logic pending, sample;
  logic a_hit, a_miss, b_hit, b_miss;
  logic state_edge, restart, dec_a, dec_b, zero_a, zero_b;

  function automatic logic is_factor(input logic [W-1:0] ans,
                                     input logic [W-1:0] p,
                                     input logic [W-1:0] q);
    is_factor = (ans != '0) && ((ans == p) || (ans == q));
  endfunction

  // A pending verdict blocks sampling so the controller never sees it change mid-latency.
  assign pending = (judg_q != JUDG_NONE) || (wrong_q != WRONG_NONE);
  assign sample  = (STATE == ST_INPUT) && !pending;

  assign a_hit  = sample && ANS_A_VLD && is_factor(ANS_A, FACT_P, FACT_Q);
  assign a_miss = sample && ANS_A_VLD && !is_factor(ANS_A, FACT_P, FACT_Q);
  assign b_hit  = sample && ANS_B_VLD && !lock_b_q && is_factor(ANS_B, FACT_P, FACT_Q);
  assign b_miss = sample && ANS_B_VLD && !lock_b_q && !is_factor(ANS_B, FACT_P, FACT_Q);

  assign state_edge = (STATE != prev_state_q);
  assign restart    = state_edge && (STATE == ST_READY) &&
                      ((prev_state_q == ST_WIN) || (prev_state_q == ST_LOSE));
  assign dec_a      = state_edge && (STATE == ST_OUCH);
  assign dec_b      = state_edge && (STATE == ST_GOOD);

  always_comb begin
    judg_d       = judg_q;
    wrong_d      = wrong_q;
    lock_cnt_d   = lock_cnt_q;
    hp_d         = hp_q;
    prev_state_d = STATE;

    if (STATE != ST_INPUT) begin
      judg_d  = JUDG_NONE;
      wrong_d = WRONG_NONE;
    end else if (!pending) begin
      if (a_hit && b_hit) begin
        judg_d  = JUDG_BOTH;
        wrong_d = WRONG_A_OK;
      end else if (a_hit) begin
        judg_d  = JUDG_A;
        wrong_d = WRONG_A_OK;
      end else if (b_hit) begin
        judg_d  = JUDG_B;
        wrong_d = WRONG_NONE;
      end else if (a_miss) begin
        judg_d  = JUDG_NONE;
        wrong_d = WRONG_A_BAD;
      end
    end

    // Lockout survives only across the INPUT/WRONG loop of a single question.
    if ((STATE != ST_INPUT) && (STATE != ST_WRONG)) lock_cnt_d = '0;
    else if (b_miss)                              lock_cnt_d = LCW'(LOCK_CYC);
    else if (lock_cnt_q != '0)                    lock_cnt_d = lock_cnt_q - LCW'(1);
    lock_b_d = (lock_cnt_d != '0);

    // Flag reads the counters' registered zero, so it trails the decrement by one cycle.
    if (restart)               hp_d = HP_NONE;
    else if (hp_q == HP_NONE) begin
      if (zero_b)      hp_d = HP_B_OUT;
      else if (zero_a) hp_d = HP_A_OUT;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      judg_q       <= JUDG_NONE;
      wrong_q      <= WRONG_NONE;
      hp_q         <= HP_NONE;
      lock_b_q     <= 1'b0;
      lock_cnt_q   <= '0;
      prev_state_q <= ST_READY;
    end else begin
      judg_q       <= judg_d;
      wrong_q      <= wrong_d;
      hp_q         <= hp_d;
      lock_b_q     <= lock_b_d;
      lock_cnt_q   <= lock_cnt_d;
      prev_state_q <= prev_state_d;
    end
  end

  hp_counter #(.CW(HPW), .INIT(HP_INIT), .DMG(DMG)) u_hp_a (
    .CLK    (CLK),
    .RST    (RST),
    .dec    (dec_a),
    .reload (restart),
    .cnt    (HP_A),
    .zero   (zero_a)
  );

  hp_counter #(.CW(HPW), .INIT(HP_INIT), .DMG(DMG)) u_hp_b (
    .CLK    (CLK),
    .RST    (RST),
    .dec    (dec_b),
    .reload (restart),
    .cnt    (HP_B),
    .zero   (zero_b)
  );

  assign JUDG   = judg_q;
  assign WRONG  = wrong_q;
  assign HP     = hp_q;
  assign LOCK_B = lock_b_q;

endmodule

// File: doc/judge_hp.md
Name: judge_hp

Overview:
- Answer judge and hit-point keeper for the two-player factorization game.
- Watches the game STATE broadcast by the game controller and samples both players' submitted answers during INPUT.
- Returns to the controller the verdict codes (JUDG, WRONG) and the HP-exhausted flag (HP) that drive its transitions.
- Owns both players' HP counters and player B's wrong-answer lockout.

Parameters:
- W, 8: answer/factor width in bits.
- HP_INIT, 3: HP loaded at reset and at game restart.
- DMG, 1: HP removed per lost round.
- LOCK_CYC, 4: cycles player B is locked out after a wrong answer.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-high.
- STATE  in  4  current game state from the controller.
- FACT_P  in  W  first correct factor of the current question.
- FACT_Q  in  W  second correct factor of the current question.
- ANS_A_VLD  in  1  one-cycle strobe, player A answer valid.
- ANS_A  in  W  player A answer.
- ANS_B_VLD  in  1  one-cycle strobe, player B answer valid.
- ANS_B  in  W  player B answer.
- JUDG  out  2  verdict code to controller.
- WRONG  out  2  wrong-answer code to controller.
- HP  out  2  00 none, 01 player B HP exhausted, 10 player A HP exhausted.
- HP_A  out  $clog2(HP_INIT+1)  player A HP.
- HP_B  out  $clog2(HP_INIT+1)  player B HP.
- LOCK_B  out  1  player B lockout active.

Behaviour:
- All outputs are registered.
- Reset values: JUDG=00, WRONG=00, HP=00, HP_A=HP_B=HP_INIT, LOCK_B=0, lock counter=0, prev_state=READY.
- RST asserted mid-game restores all reset values on the next edge, regardless of STATE.
- State codes: READY=0010, QUESTION=0011, INPUT=0100, DRAW=0110, WRONG=0111, GOOD=1000, OUCH=1001, WIN=1010, LOSE=1011.
- Correctness: an answer is correct iff it is nonzero and equals FACT_P or FACT_Q. Comparison is W-bit unsigned.
- Sampling:
  - Answers are sampled only when STATE==INPUT and no verdict is pending (JUDG/WRONG == 00/00).
  - ANS_B_VLD is ignored while LOCK_B=1.
  - Strobes in any other state are discarded, not queued.
- Verdict encoding, registered one cycle after the strobe:
  - A wrong, B absent/wrong/locked: JUDG=00, WRONG=11.
  - A correct, B absent/wrong/locked: JUDG=01, WRONG=01.
  - B correct, A absent/wrong: JUDG=10, WRONG=00.
  - A and B correct in the same cycle: JUDG=11, WRONG=01.
  - A and B both wrong in the same cycle: A-wrong code, and B lockout also starts.
  - B wrong alone: verdict stays 00/00; lockout starts.
- Verdict hold and clear:
  - The verdict holds while STATE==INPUT, covering the controller's two-register latency.
  - It clears to 00/00 on the first cycle STATE!=INPUT.
  - After WRONG returns to INPUT, judging restarts with a cleared verdict. Stale answers are never re-judged.
- Lockout:
  - B wrong sets LOCK_B=1 and loads the counter with LOCK_CYC.
  - The counter decrements every cycle; LOCK_B drops when it reaches 0.
  - Lockout clears immediately when STATE leaves INPUT or WRONG.
  - A new B-wrong while locked is impossible, since strobes are ignored.
- HP update (edge-detected on prev_state!=STATE):
  - Entry to GOOD: HP_B -= DMG, saturating at 0.
  - Entry to OUCH: HP_A -= DMG, saturating at 0.
  - DRAW: no damage.
  - HP is set one cycle after the decrement: 01 if HP_B==0, else 10 if HP_A==0. It holds until restart.
- Restart: entry to READY from WIN or LOSE reloads HP_A=HP_B=HP_INIT and clears HP to 00. Entry to READY from GOOD/OUCH/DRAW keeps the HP values.
- Width: HP registers are sized $clog2(HP_INIT+1). DMG > current HP saturates to 0, with no wrap.

Decomposition:
- Shared package game_pkg:
  - The state-code localparams above, also used by the controller.
  - JUDG/WRONG/HP code constants.
- One natural sub-module: hp_counter. It holds a saturating decrement with reload, a zero flag, and a width parameter, and is instantiated once per player.

Test Plan:
1. RST, then STATE=INPUT, FACT_P=3, FACT_Q=7, ANS_A=7 strobe -> next cycle JUDG=01, WRONG=01. STATE=GOOD -> JUDG/WRONG=00/00 and HP_B 3->2.
2. STATE=INPUT, ANS_A=5 strobe -> JUDG=00, WRONG=11. STATE=WRONG then INPUT -> verdict 00/00, no re-judge without a new strobe.
3. Same cycle ANS_A=3 and ANS_B=7 valid -> JUDG=11, WRONG=01. STATE=DRAW -> HP_A and HP_B unchanged.
4. ANS_B=4 strobe -> LOCK_B=1 for 4 cycles, and ANS_B=3 during lockout is ignored. After lockout, ANS_B=3 -> JUDG=10, WRONG=00.
5. HP_B=1, enter GOOD -> HP_B=0 and next cycle HP=01. STATE WIN->READY -> HP_A=HP_B=3, HP=00.
6. Assert RST while JUDG=01 and LOCK_B=1 -> next edge all outputs return to reset values.
